// File: rtl/uart_rx_controller.sv
// UART receive engine: 16x oversampled start detect, LSB-first data shift,
// optional parity and one/two stop bits, one write (or overrun pulse) per frame.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// RX_IDLE    | line idle, waiting for a low sample
// RX_START   | counting to mid start bit to confirm or reject it as a glitch
// RX_DATA    | sampling data bits at mid-bit, shifting in LSB first
// RX_PARITY  | sampling the parity bit and comparing against accumulated parity
// RX_STOP_1  | sampling first stop bit; completes frame unless two stop bits
// RX_STOP_2  | sampling second stop bit; completes frame
module uart_rx_controller #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_clk_en,
   input  logic                 rxd,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 double_stop_bit,
   input  logic                 rx_queue_full,
   output logic                 rx_queue_we,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   output logic                 rx_busy
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] SMP_MID_START = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SMP_MID_BIT   = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST      = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP_1,
      RX_STOP_2
   } rx_state_t;

   rx_state_t            state, state_nxt;
   logic                 rxd_meta, rxs;
   logic [SW-1:0]        smp_cnt, smp_nxt;
   logic [BW-1:0]        bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0] shift_reg, shift_nxt;
   logic                 par_acc, par_nxt;
   logic                 perr, perr_nxt;
   logic                 ferr, ferr_nxt;
   logic                 cfg_par_en, cfg_par_en_nxt;
   logic                 cfg_par_odd, cfg_par_odd_nxt;
   logic                 cfg_dstop, cfg_dstop_nxt;
   logic                 frame_done;

   // two-flop synchronizer on the asynchronous serial line; idles high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxd_meta <= 1'b1;
         rxs      <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxs      <= rxd_meta;
      end
   end

   // next-state and datapath; everything holds unless an oversample tick arrives
   always_comb begin
      state_nxt       = state;
      smp_nxt         = smp_cnt;
      bit_nxt         = bit_cnt;
      shift_nxt       = shift_reg;
      par_nxt         = par_acc;
      perr_nxt        = perr;
      ferr_nxt        = ferr;
      cfg_par_en_nxt  = cfg_par_en;
      cfg_par_odd_nxt = cfg_par_odd;
      cfg_dstop_nxt   = cfg_dstop;
      frame_done      = 1'b0;
      if (rx_clk_en) begin
         case (state)
            RX_IDLE: begin
               if (!rxs) begin
                  state_nxt = RX_START;
                  smp_nxt   = '0;
               end
            end
            RX_START: begin
               smp_nxt = smp_cnt + 1'b1;
               if (smp_cnt == SMP_MID_START) begin
                  if (!rxs) begin
                     cfg_par_en_nxt  = parity_en;
                     cfg_par_odd_nxt = parity_odd;
                     cfg_dstop_nxt   = double_stop_bit;
                     smp_nxt         = '0;
                     bit_nxt         = '0;
                     par_nxt         = 1'b0;
                     perr_nxt        = 1'b0;
                     ferr_nxt        = 1'b0;
                     state_nxt       = RX_DATA;
                  end else begin
                     state_nxt = RX_IDLE;
                  end
               end
            end
            RX_DATA: begin
               smp_nxt = smp_cnt + 1'b1;
               if (smp_cnt == SMP_MID_BIT) begin
                  shift_nxt = {rxs, shift_reg[DATA_BITS-1:1]};
                  par_nxt   = par_acc ^ rxs;
                  bit_nxt   = bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) begin
                     state_nxt = cfg_par_en ? RX_PARITY : RX_STOP_1;
                  end
               end
            end
            RX_PARITY: begin
               smp_nxt = smp_cnt + 1'b1;
               if (smp_cnt == SMP_MID_BIT) begin
                  perr_nxt  = rxs ^ par_acc ^ cfg_par_odd;
                  state_nxt = RX_STOP_1;
               end
            end
            RX_STOP_1: begin
               smp_nxt = smp_cnt + 1'b1;
               if (smp_cnt == SMP_MID_BIT) begin
                  ferr_nxt = ~rxs;
                  if (cfg_dstop) begin
                     state_nxt = RX_STOP_2;
                  end else begin
                     state_nxt  = RX_IDLE;
                     frame_done = 1'b1;
                  end
               end
            end
            RX_STOP_2: begin
               smp_nxt = smp_cnt + 1'b1;
               if (smp_cnt == SMP_MID_BIT) begin
                  ferr_nxt   = ferr | ~rxs;
                  state_nxt  = RX_IDLE;
                  frame_done = 1'b1;
               end
            end
            default: state_nxt = RX_IDLE;
         endcase
      end
   end

   // frame state register, counters and accumulators
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RX_IDLE;
         smp_cnt     <= '0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         par_acc     <= 1'b0;
         perr        <= 1'b0;
         ferr        <= 1'b0;
         cfg_par_en  <= 1'b0;
         cfg_par_odd <= 1'b0;
         cfg_dstop   <= 1'b0;
      end else begin
         state       <= state_nxt;
         smp_cnt     <= smp_nxt;
         bit_cnt     <= bit_nxt;
         shift_reg   <= shift_nxt;
         par_acc     <= par_nxt;
         perr        <= perr_nxt;
         ferr        <= ferr_nxt;
         cfg_par_en  <= cfg_par_en_nxt;
         cfg_par_odd <= cfg_par_odd_nxt;
         cfg_dstop   <= cfg_dstop_nxt;
      end
   end

   // one-clk write or overrun strobe after completion; word and flags held between writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_queue_we   <= 1'b0;
         rx_overrun    <= 1'b0;
         rx_data       <= '0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
      end else begin
         rx_queue_we <= frame_done & ~rx_queue_full;
         rx_overrun  <= frame_done & rx_queue_full;
         if (frame_done && !rx_queue_full) begin
            rx_data       <= shift_reg;
            rx_parity_err <= perr;
            rx_frame_err  <= ferr_nxt;
         end
      end
   end

   assign rx_busy = (state != RX_IDLE);

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
UART receive engine, the receive-side counterpart of the UART TX path. It oversamples the serial line 16x using the shared baud-tick enable and detects and validates the start bit. It shifts in data bits LSB-first, checks optional parity and one or two stop bits, then pushes each received byte with its error flags into the RX queue. It sits between the pad-side rxd input and the RX FIFO of the UART peripheral.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8).
OVERSAMPLE, 16, rx_clk_en ticks per bit period (power of two, >=8).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
rx_clk_en  input  1  oversample tick; one clk-cycle pulse, OVERSAMPLE per bit.
rxd  input  1  raw serial line, asynchronous; idle high.
parity_en  input  1  frame carries a parity bit.
parity_odd  input  1  1 = odd parity, 0 = even.
double_stop_bit  input  1  frame has two stop bits.
rx_queue_full  input  1  RX FIFO cannot accept a write.
rx_queue_we  output  1  one-cycle write strobe to the RX FIFO.
rx_data  output  DATA_BITS  received word, valid while rx_queue_we=1.
rx_parity_err  output  1  parity mismatch flag, valid with rx_queue_we.
rx_frame_err  output  1  stop bit(s) sampled low, valid with rx_queue_we.
rx_overrun  output  1  one-cycle pulse: frame completed while queue full, word dropped.
rx_busy  output  1  high in any state other than RX_IDLE.

Behaviour:
- Reset (reset=0, async): state RX_IDLE. Synchronizer flops = 1. Counters, shift register and parity = 0. All outputs 0. Reset mid-frame abandons the frame; no write follows.
- rxd passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized value rxs. This adds a 2-clk input latency.
- The state register and counters advance only on clk edges with rx_clk_en=1, except the output strobes (see below).
- smp_cnt: log2(OVERSAMPLE) bits, wraps naturally. bit_cnt: counts data bits 0..DATA_BITS-1.
- RX_IDLE: on a tick with rxs=0, go to RX_START and set smp_cnt=0.
- RX_START: on each tick smp_cnt++. On the tick where smp_cnt==OVERSAMPLE/2-1 (mid start bit):
  - rxs=0: latch parity_en, parity_odd and double_stop_bit into config registers (held for the rest of the frame). Clear smp_cnt, bit_cnt and parity. Go to RX_DATA.
  - rxs=1: treat as a glitch and return to RX_IDLE. No write, no error.
- RX_DATA: each tick smp_cnt++. On the tick where smp_cnt==OVERSAMPLE-1 (mid-bit):
  - shift rxs into the MSB of the shift register (right shift, LSB-first on the wire);
  - parity ^= rxs; bit_cnt++.
  - After sampling bit DATA_BITS-1, go to RX_PARITY if latched parity_en, else RX_STOP_1.
- RX_PARITY: sample at smp_cnt==OVERSAMPLE-1. perr = rxs ^ parity ^ parity_odd. Go to RX_STOP_1.
- RX_STOP_1: sample at mid-bit. ferr = ~rxs. If latched double_stop_bit, go to RX_STOP_2; else the frame completes.
- RX_STOP_2: sample at mid-bit. ferr |= ~rxs. The frame completes.
- Frame completion happens on the final mid-stop sample edge: state returns to RX_IDLE. A new start bit can therefore be detected from the next tick onward; stop bits are not waited out in full.
- Completion with rx_queue_full=0 (sampled on the completion edge): on the next clk cycle rx_queue_we=1 for exactly one clk. rx_data, rx_parity_err and rx_frame_err are registered and stable while it is high. The word is written even when an error flag is set.
- Completion with rx_queue_full=1: no write. rx_overrun=1 for exactly one clk on the next cycle.
- Outside those strobes, rx_queue_we=0 and rx_overrun=0. rx_data and the error flags hold their last value.
- A low line stuck in stop position (break) yields frame_err words; there is no separate break detection.
- Configuration changes mid-frame do not affect the current frame.

Test Plan:
- 8N1, rx_clk_en every 4th clk, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one rx_queue_we pulse with rx_data=0xA5, both errors 0. rx_busy high from start detection to the mid-stop sample.
- Start-bit glitch: rxd low for 5 ticks, then high -> back to RX_IDLE, no rx_queue_we, no rx_overrun.
- 8E1, send 0x03 with parity bit 1 (wrong) -> rx_data=0x03, rx_parity_err=1. Repeat with parity_odd=1 and parity bit 1 -> rx_parity_err=0.
- 8N2, second stop bit driven low -> rx_data written, rx_frame_err=1. Two back-to-back 8N1 frames 0x55, 0xAA with no idle gap -> two writes in order.
- rx_queue_full=1 during a 0x7E frame -> no rx_queue_we, one-cycle rx_overrun. Deassert full and send 0x81 -> normal write.
- Assert reset in the middle of data bit 4 of 0xFF, release, then send 0x12 -> only 0x12 is written, all outputs 0 during reset.
